racetrack_req_arbiter: RTL and testbench

- Two-port front end that shares one racetrack memory bank, including its sequencing FSM, between the core instruction port and data port.
- Arbitrates round-robin and latches the winning request.
- Holds the bank enable and operands stable until the bank reports completion, then routes the response to the owning port.
- Adds a response-timeout watchdog and a sticky error flag.

---
 rtl/racetrack_req_arbiter_pkg.sv | 18 +
 rtl/racetrack_req_arbiter_rr_arbiter2.sv | 21 ++
 rtl/racetrack_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_racetrack_req_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/racetrack_req_arbiter_pkg.sv
// Shared types and constants for the racetrack bank request arbiter.
package racetrack_req_arbiter_pkg;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [2:0] LIM_FUNCT_NONE         = 3'b000;
  localparam int         TIMEOUT_CYCLES_DEFAULT = 1000;

endpackage

// File: rtl/racetrack_req_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; bit 0 is the instruction port, bit 1 the data port.
module rr_arbiter2
  import racetrack_req_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Contention: the port that did not win last time goes first.
      2'b11:   gnt_o = (last_owner_i == INSTR) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/racetrack_req_arbiter.sv
// Shares one racetrack bank between instruction and data ports: round-robin grant,
// held operands while the bank works, one-cycle routed response and a timeout watchdog.
module racetrack_req_arbiter
  import racetrack_req_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int TO_WIDTH       = 10,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [2:0]            data_lim_funct_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  instr_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [2:0]            mem_lim_funct_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  timeout_sticky_o
);

  arb_state_e            state_q;
  owner_e                owner_q, last_owner_q;
  logic                  en_q, we_q, err_q, sticky_q;
  logic [3:0]            be_q;
  logic [2:0]            lim_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [TO_WIDTH-1:0]   cnt_q;

  logic [1:0] arb_gnt, gnt;
  logic       arb_open;

  rr_arbiter2 u_arb (
    .req_i       ({data_req_i, instr_req_i}),
    .last_owner_i(last_owner_q),
    .gnt_o       (arb_gnt)
  );

  assign arb_open = !rst_i && (state_q != BUSY);
  assign gnt      = arb_open ? arb_gnt : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= INSTR;
      last_owner_q <= INSTR;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      lim_q        <= LIM_FUNCT_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (gnt != 2'b00) begin
            state_q      <= BUSY;
            owner_q      <= gnt[1] ? DATA : INSTR;
            last_owner_q <= gnt[1] ? DATA : INSTR;
            en_q         <= 1'b1;
            cnt_q        <= TO_WIDTH'(TIMEOUT_CYCLES);
            if (gnt[1]) begin
              we_q    <= data_we_i;
              be_q    <= data_be_i;
              lim_q   <= data_lim_funct_i;
              addr_q  <= data_addr_i;
              wdata_q <= data_wdata_i;
            end else begin
              we_q    <= 1'b0;
              be_q    <= 4'b1111;
              lim_q   <= LIM_FUNCT_NONE;
              addr_q  <= instr_addr_i;
              wdata_q <= '0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - TO_WIDTH'(1);
          // A completion in the last allowed cycle still counts as success.
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q <= TO_WIDTH'(1)) begin
            rdata_q  <= '0;
            err_q    <= 1'b1;
            sticky_q <= 1'b1;
            en_q     <= 1'b0;
            state_q  <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_gnt_o      = gnt[0];
  assign data_gnt_o       = gnt[1];
  assign instr_rvalid_o   = (state_q == RESP) && (owner_q == INSTR);
  assign data_rvalid_o    = (state_q == RESP) && (owner_q == DATA);
  assign instr_err_o      = instr_rvalid_o && err_q;
  assign data_err_o       = data_rvalid_o && err_q;
  assign instr_rdata_o    = rdata_q;
  assign data_rdata_o     = rdata_q;
  assign mem_en_o         = en_q;
  assign mem_we_o         = we_q;
  assign mem_be_o         = be_q;
  assign mem_lim_funct_o  = lim_q;
  assign mem_addr_o       = addr_q;
  assign mem_wdata_o      = wdata_q;
  assign busy_o           = (state_q != IDLE);
  assign timeout_sticky_o = sticky_q;

endmodule

// File: tb/tb_racetrack_req_arbiter.sv
// Scoreboard bench for racetrack_req_arbiter: directed requests, a scripted bank, a decoupled monitor.
module tb_racetrack_req_arbiter;
  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [AW-1:0] instr_addr_i;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]    data_be_i;
  logic [2:0]    data_lim_funct_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i, data_rdata_o;
  logic          mem_en_o, mem_we_o, mem_rvalid_i;
  logic [3:0]    mem_be_o;
  logic [2:0]    mem_lim_funct_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          busy_o, timeout_sticky_o;

  always #5 clk = ~clk;

  racetrack_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TO_WIDTH(10), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_lim_funct_i(data_lim_funct_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o), .instr_err_o(instr_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_lim_funct_o(mem_lim_funct_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .timeout_sticky_o(timeout_sticky_o)
  );

  typedef struct {
    logic [AW-1:0] addr; logic we; logic [3:0] be; logic [2:0] lim; logic [DW-1:0] wdata;
  } req_t;
  typedef struct { int lat; logic [DW-1:0] rdata; } bank_t;
  typedef struct {
    bit port; logic [DW-1:0] rdata; bit err; int lat;
    logic we; logic [3:0] be; logic [2:0] lim; logic [AW-1:0] addr; logic [DW-1:0] wdata;
  } exp_t;

  req_t  iq[$], dq[$];
  bank_t bq[$];
  exp_t  eq[$];
  bit    gq[$];
  int    n_chk = 0, n_fail = 0;
  int    cyc = 0;
  int    gnt_cyc[2];
  int    idle_gnts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // port: 0 instr, 1 data. blat=0 means the bank never answers.
  task automatic issue(bit port, logic [AW-1:0] addr, logic we, logic [3:0] be, logic [2:0] lim,
                       logic [DW-1:0] wdata, int blat, logic [DW-1:0] brd, bit rsp);
    req_t r; bank_t b; exp_t e;
    r.addr = addr; r.we = we; r.be = be; r.lim = lim; r.wdata = wdata;
    if (port) dq.push_back(r); else iq.push_back(r);
    b.lat = blat; b.rdata = brd;
    bq.push_back(b);
    gq.push_back(port);
    if (rsp) begin
      e.port  = port;
      e.err   = (blat == 0);
      e.rdata = e.err ? 32'h0 : brd;
      e.lat   = e.err ? 9 : blat + 1;
      e.we    = port ? we : 1'b0;
      e.be    = port ? be : 4'hF;
      e.lim   = port ? lim : 3'b000;
      e.addr  = addr;
      e.wdata = wdata;
      eq.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (eq.size() == 0 && gq.size() == 0 && iq.size() == 0 && dq.size() == 0 &&
          !instr_req_i && !data_req_i && !busy_o) return;
    end
    chk("drain_timeout", 64'(0), 64'(1));
  endtask

  // Instruction requester: holds req and fields until granted.
  initial begin
    bit g; req_t r;
    instr_req_i = 1'b0; instr_addr_i = '0;
    forever begin
      @(negedge clk); g = instr_gnt_o;
      @(posedge clk); #1;
      if (g) instr_req_i = 1'b0;
      if (!instr_req_i && !rst_i && iq.size() > 0) begin
        r = iq.pop_front(); instr_addr_i = r.addr; instr_req_i = 1'b1;
      end
    end
  end

  // Data requester.
  initial begin
    bit g; req_t r;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_lim_funct_i = '0;
    data_addr_i = '0; data_wdata_i = '0;
    forever begin
      @(negedge clk); g = data_gnt_o;
      @(posedge clk); #1;
      if (g) data_req_i = 1'b0;
      if (!data_req_i && !rst_i && dq.size() > 0) begin
        r = dq.pop_front();
        data_we_i = r.we; data_be_i = r.be; data_lim_funct_i = r.lim;
        data_addr_i = r.addr; data_wdata_i = r.wdata; data_req_i = 1'b1;
      end
    end
  end

  // Scripted bank: answers after the scheduled number of enabled cycles.
  initial begin
    int en_cnt; bank_t cur;
    en_cnt = 0; cur.lat = 0; cur.rdata = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst_i || !mem_en_o) begin
        en_cnt = 0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      end else begin
        if (en_cnt == 0) begin
          if (bq.size() > 0) cur = bq.pop_front();
          else begin cur.lat = 0; cur.rdata = '0; end
        end
        en_cnt++;
        mem_rvalid_i = (cur.lat != 0) && (en_cnt == cur.lat);
        mem_rdata_i  = mem_rvalid_i ? cur.rdata : 32'h0BAD0BAD;
      end
    end
  end

  // Monitor: grants and responses are checked against the queues.
  initial begin
    int en_len; bit stable; bit p; exp_t e;
    logic [61:0] cap;
    en_len = 0; stable = 1'b1; cap = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin en_len = 0; stable = 1'b1; continue; end
      if (mem_en_o) begin
        if (en_len == 0) cap = {mem_we_o, mem_be_o, mem_lim_funct_o, mem_addr_o, mem_wdata_o};
        else if (cap !== {mem_we_o, mem_be_o, mem_lim_funct_o, mem_addr_o, mem_wdata_o}) stable = 1'b0;
        en_len++;
      end
      if (instr_gnt_o || data_gnt_o) begin
        if (!busy_o) idle_gnts++;
        if (gq.size() == 0) chk("gnt_unexpected", 64'(1), 64'(0));
        else begin
          p = gq.pop_front();
          chk("gnt_port", 64'({data_gnt_o, instr_gnt_o}), 64'(p ? 2 : 1));
        end
        gnt_cyc[data_gnt_o ? 1 : 0] = cyc;
      end
      if (instr_rvalid_o || data_rvalid_o) begin
        if (eq.size() == 0) chk("rvalid_unexpected", 64'(1), 64'(0));
        else begin
          e = eq.pop_front();
          chk("rsp_port", 64'({data_rvalid_o, instr_rvalid_o}), 64'(e.port ? 2 : 1));
          chk("rsp_rdata", 64'(e.port ? data_rdata_o : instr_rdata_o), 64'(e.rdata));
          chk("rsp_err", 64'(e.port ? data_err_o : instr_err_o), 64'(e.err));
          chk("rsp_latency", 64'(cyc - gnt_cyc[e.port]), 64'(e.lat));
          chk("en_cycles", 64'(en_len), 64'(e.lat - 1));
          chk("ops_stable", 64'(stable), 64'(1));
          chk("ops", 64'(cap[61:32]), 64'({e.we, e.be, e.lim, e.addr}));
          if (e.port) chk("wdata", 64'(cap[31:0]), 64'(e.wdata));
        end
        en_len = 0; stable = 1'b1;
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mem_en", 64'(mem_en_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_sticky", 64'(timeout_sticky_o), 64'(0));
    chk("rst_rvalid", 64'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}), 64'(0));
    chk("rst_mem_ops", 64'({mem_we_o, mem_be_o, mem_lim_funct_o, mem_addr_o}), 64'(0));

    // Contention straight after reset: DATA, INSTR, DATA, INSTR, back to back.
    idle_gnts = 0;
    issue(1, 22'h100, 1'b0, 4'hF, 3'b000, 32'h0, 3, 32'hD0D0_0001, 1);
    issue(0, 22'h200, 1'b0, 4'h0, 3'b000, 32'h0, 2, 32'h1A1A_0002, 1);
    issue(1, 22'h101, 1'b1, 4'h5, 3'b001, 32'h55AA_55AA, 5, 32'hD1D1_0003, 1);
    issue(0, 22'h201, 1'b0, 4'h0, 3'b000, 32'h0, 4, 32'h1B1B_0004, 1);
    wait_done();
    chk("contention_idle_grants", 64'(idle_gnts), 64'(1));

    // Instruction-only read, bank answers after 7 enabled cycles.
    issue(0, 22'h00010, 1'b0, 4'h0, 3'b000, 32'h0, 7, 32'hDEAD_BEEF, 1);
    wait_done();

    // Data logic-in-memory write.
    issue(1, 22'h00123, 1'b1, 4'b0011, 3'b010, 32'h0000_A5A5, 4, 32'h0000_1111, 1);
    wait_done();

    // Bank never answers: error response after the watchdog expires.
    chk("sticky_before_timeout", 64'(timeout_sticky_o), 64'(0));
    issue(1, 22'h3FFFFF, 1'b0, 4'hF, 3'b000, 32'h0, 0, 32'h0, 1);
    wait_done();
    chk("sticky_after_timeout", 64'(timeout_sticky_o), 64'(1));
    issue(0, 22'h00020, 1'b0, 4'h0, 3'b000, 32'h0, 2, 32'hCAFE_F00D, 1);
    wait_done();
    chk("sticky_held", 64'(timeout_sticky_o), 64'(1));

    // Reset in the middle of a BUSY phase drops the transaction.
    issue(0, 22'h00300, 1'b0, 4'h0, 3'b000, 32'h0, 0, 32'h0, 0);
    begin
      int n;
      n = 0;
      while (!mem_en_o && n < 50) begin @(negedge clk); n++; end
      chk("reach_busy", 64'(mem_en_o), 64'(1));
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_mem_en", 64'(mem_en_o), 64'(0));
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'(0));
    chk("midrst_sticky", 64'(timeout_sticky_o), 64'(0));
    repeat (12) @(negedge clk);
    chk("midrst_quiet", 64'({busy_o, instr_rvalid_o, data_rvalid_o}), 64'(0));
    bq.delete();

    // Normal service after the reset.
    issue(1, 22'h00040, 1'b0, 4'hF, 3'b000, 32'h0, 1, 32'h0123_4567, 1);
    wait_done();
    chk("scoreboard_empty", 64'(eq.size() + gq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
